// File: rtl/a2d_arb_pkg.sv
// Shared types and constants for the two-requester A2D converter arbiter.
package a2d_arb_pkg;

    localparam int RES_W  = 12;
    localparam int CHNL_W = 3;

    localparam logic REQ_MOTION = 1'b0;
    localparam logic REQ_BATT   = 1'b1;

    localparam logic [RES_W-1:0] TIMEOUT_RES = 12'hFFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT
    } state_e;

    // Round-robin pick: on a tie the requester not served last wins.
    function automatic logic pick_grantee(input logic pend0, input logic pend1,
                                          input logic last);
        logic g;
        if (pend0 && pend1) begin
            g = ~last;
        end else if (pend0) begin
            g = REQ_MOTION;
        end else begin
            g = REQ_BATT;
        end
        return g;
    endfunction

endpackage

// File: rtl/a2d_arb_req_latch.sv
// Per-requester pending flag and channel capture; a start is ignored while pending.
module a2d_arb_req_latch
    import a2d_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic [CHNL_W-1:0] chnnl_i,
    input  logic              clr_i,
    output logic              pend_o,
    output logic [CHNL_W-1:0] chnnl_o
);

    logic              pend_q, pend_d;
    logic [CHNL_W-1:0] chnnl_q, chnnl_d;

    // The flag stays set through service, so it also blocks restarts in WAIT.
    always_comb begin
        pend_d  = pend_q;
        chnnl_d = chnnl_q;
        if (clr_i) begin
            pend_d = 1'b0;
        end else if (set_i && !pend_q) begin
            pend_d  = 1'b1;
            chnnl_d = chnnl_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            chnnl_q <= '0;
        end else begin
            pend_q  <= pend_d;
            chnnl_q <= chnnl_d;
        end
    end

    assign pend_o  = pend_q;
    assign chnnl_o = chnnl_q;

endmodule

// File: rtl/a2d_arbiter.sv
// Round-robin sharing of one A2D_intf converter between motion and battery requesters.
// Optional WAIT watchdog enabled by defining A2D_ARB_TIMEOUT_EN.
module a2d_arbiter
    import a2d_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_strt,
    input  logic [CHNL_W-1:0] req0_chnnl,
    output logic              req0_cmplt,
    output logic [RES_W-1:0]  req0_res,
    input  logic              req1_strt,
    input  logic [CHNL_W-1:0] req1_chnnl,
    output logic              req1_cmplt,
    output logic [RES_W-1:0]  req1_res,
    output logic              strt_cnv,
    output logic [CHNL_W-1:0] chnnl,
    input  logic              cnv_cmplt,
    input  logic [RES_W-1:0]  res,
    output logic              err_timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("a2d_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic              pend0, pend1;
    logic [CHNL_W-1:0] lch0, lch1;
    logic              clr0, clr1;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              strt_cnv_q, strt_cnv_d;
    logic [CHNL_W-1:0] chnnl_q, chnnl_d;
    logic              cmplt0_q, cmplt0_d;
    logic              cmplt1_q, cmplt1_d;
    logic [RES_W-1:0]  res0_q, res0_d;
    logic [RES_W-1:0]  res1_q, res1_d;
    logic              done;
    logic [RES_W-1:0]  done_res;

`ifdef A2D_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;

    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    a2d_arb_req_latch u_req0_latch (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_i   (req0_strt),
        .chnnl_i (req0_chnnl),
        .clr_i   (clr0),
        .pend_o  (pend0),
        .chnnl_o (lch0)
    );

    a2d_arb_req_latch u_req1_latch (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_i   (req1_strt),
        .chnnl_i (req1_chnnl),
        .clr_i   (clr1),
        .pend_o  (pend1),
        .chnnl_o (lch1)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        strt_cnv_d = 1'b0;
        chnnl_d    = chnnl_q;
        cmplt0_d   = 1'b0;
        cmplt1_d   = 1'b0;
        res0_d     = res0_q;
        res1_d     = res1_q;
        done       = 1'b0;
        done_res   = res;
        clr0       = 1'b0;
        clr1       = 1'b0;
`ifdef A2D_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif

        case (state_q)
            IDLE: begin
                // strt_cnv/chnnl are registered, so they are set up on the way into ISSUE.
                if (pend0 || pend1) begin
                    grant_d    = pick_grantee(pend0, pend1, last_q);
                    strt_cnv_d = 1'b1;
                    chnnl_d    = (grant_d == REQ_BATT) ? lch1 : lch0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef A2D_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (cnv_cmplt) begin
                    done     = 1'b1;
                    done_res = res;
                end
`ifdef A2D_ARB_TIMEOUT_EN
                else if (cnt_inc == CNT_LIMIT) begin
                    done     = 1'b1;
                    done_res = TIMEOUT_RES;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d = IDLE;
            last_d  = grant_q;
            if (grant_q == REQ_BATT) begin
                res1_d   = done_res;
                cmplt1_d = 1'b1;
                clr1     = 1'b1;
            end else begin
                res0_d   = done_res;
                cmplt0_d = 1'b1;
                clr0     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= REQ_MOTION;
            last_q     <= REQ_BATT;
            strt_cnv_q <= 1'b0;
            chnnl_q    <= '0;
            cmplt0_q   <= 1'b0;
            cmplt1_q   <= 1'b0;
            res0_q     <= '0;
            res1_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            strt_cnv_q <= strt_cnv_d;
            chnnl_q    <= chnnl_d;
            cmplt0_q   <= cmplt0_d;
            cmplt1_q   <= cmplt1_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
        end
    end

`ifdef A2D_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign strt_cnv   = strt_cnv_q;
    assign chnnl      = chnnl_q;
    assign req0_cmplt = cmplt0_q;
    assign req1_cmplt = cmplt1_q;
    assign req0_res   = res0_q;
    assign req1_res   = res1_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// Self-checking bench for a2d_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model with an ADC model.
module tb_a2d_arbiter;

    localparam int TO = 16;
`ifdef A2D_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_strt = 1'b0, req1_strt = 1'b0;
    logic [2:0]  req0_chnnl = '0, req1_chnnl = '0;
    logic        req0_cmplt, req1_cmplt;
    logic [11:0] req0_res, req1_res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = '0;
    logic        err_timeout;

    always #5 clk = ~clk;

    a2d_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_strt   (req0_strt),
        .req0_chnnl  (req0_chnnl),
        .req0_cmplt  (req0_cmplt),
        .req0_res    (req0_res),
        .req1_strt   (req1_strt),
        .req1_chnnl  (req1_chnnl),
        .req1_cmplt  (req1_cmplt),
        .req1_res    (req1_res),
        .strt_cnv    (strt_cnv),
        .chnnl       (chnnl),
        .cnv_cmplt   (cnv_cmplt),
        .res         (res),
        .err_timeout (err_timeout)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ADC model
    bit          adc_busy;
    int          adc_cnt;
    int          adc_lat_cfg = -1;
    bit          adc_fixed;
    bit          adc_hang;
    logic [11:0] adc_val;

    // Reference model: outstanding requests, last served, one conversion in flight
    bit          m_pend [2];
    logic [2:0]  m_ch [2];
    int          m_last;
    bit          m_busy;
    int          m_g;
    int          m_age;
    logic        m_strt;
    logic [2:0]  m_chnnl;
    logic        m_cmplt [2];
    logic [11:0] m_res [2];
    logic        m_err;

    // Observation log
    int          tick_no;
    int          n_strt, n_c0, n_c1, t_issue;
    logic [2:0]  last_issue_ch;
    int          grants[$];

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_pend[n]  = 1'b0;
            m_ch[n]    = '0;
            m_cmplt[n] = 1'b0;
            m_res[n]   = '0;
        end
        m_last  = 1;
        m_busy  = 1'b0;
        m_g     = 0;
        m_age   = 0;
        m_strt  = 1'b0;
        m_chnnl = '0;
        m_err   = 1'b0;
    endtask

    task automatic env_reset();
        cnv_cmplt = 1'b0;
        adc_busy  = 1'b0;
        adc_cnt   = 0;
    endtask

    task automatic clear_log();
        n_strt = 0;
        n_c0   = 0;
        n_c1   = 0;
        grants.delete();
    endtask

    // One clock: capture pre-edge inputs, advance ADC and model, compare all outputs.
    task automatic tick();
        logic        s [2];
        logic [2:0]  c [2];
        logic        cc_pre, strt_pre;
        logic [11:0] r_pre;
        bit          p_pre [2];
        bit          done;
        logic [11:0] dres;

        s[0] = req0_strt;  c[0] = req0_chnnl;
        s[1] = req1_strt;  c[1] = req1_chnnl;
        cc_pre   = cnv_cmplt;
        r_pre    = res;
        strt_pre = strt_cnv;

        @(posedge clk);
        #1;
        tick_no++;

        if (!rst_n) begin
            model_reset();
            env_reset();
            return;
        end

        if (strt_pre === 1'b1) begin
            cnv_cmplt = 1'b0;
            adc_busy  = 1'b1;
            adc_cnt   = (adc_lat_cfg < 0) ? int'($urandom_range(5, 0)) : adc_lat_cfg;
        end else if (adc_busy && !adc_hang) begin
            if (adc_cnt == 0) begin
                cnv_cmplt = 1'b1;
                res       = adc_fixed ? adc_val : 12'($urandom);
                adc_busy  = 1'b0;
            end else begin
                adc_cnt--;
            end
        end

        p_pre[0]   = m_pend[0];
        p_pre[1]   = m_pend[1];
        m_strt     = 1'b0;
        m_cmplt[0] = 1'b0;
        m_cmplt[1] = 1'b0;
        done       = 1'b0;
        dres       = '0;
        if (m_busy) begin
            if (m_age >= 1 && cc_pre === 1'b1) begin
                done = 1'b1;
                dres = r_pre;
            end else if (TO_EN && m_age == TO) begin
                done  = 1'b1;
                dres  = 12'hFFF;
                m_err = 1'b1;
            end
            if (done) begin
                m_res[m_g]   = dres;
                m_cmplt[m_g] = 1'b1;
                m_pend[m_g]  = 1'b0;
                m_last       = m_g;
                m_busy       = 1'b0;
            end else begin
                m_age++;
            end
        end else if (p_pre[0] || p_pre[1]) begin
            if (p_pre[0] && p_pre[1]) m_g = 1 - m_last;
            else                      m_g = p_pre[0] ? 0 : 1;
            m_busy  = 1'b1;
            m_age   = 0;
            m_strt  = 1'b1;
            m_chnnl = m_ch[m_g];
        end
        for (int n = 0; n < 2; n++) begin
            if (s[n] === 1'b1 && !p_pre[n]) begin
                m_pend[n] = 1'b1;
                m_ch[n]   = c[n];
            end
        end

        check("strt_cnv",    32'(strt_cnv),    32'(m_strt));
        check("chnnl",       32'(chnnl),       32'(m_chnnl));
        check("req0_cmplt",  32'(req0_cmplt),  32'(m_cmplt[0]));
        check("req1_cmplt",  32'(req1_cmplt),  32'(m_cmplt[1]));
        check("req0_res",    32'(req0_res),    32'(m_res[0]));
        check("req1_res",    32'(req1_res),    32'(m_res[1]));
        check("err_timeout", 32'(err_timeout), 32'(m_err));

        if (strt_cnv === 1'b1) begin
            n_strt++;
            grants.push_back(int'(chnnl));
            last_issue_ch = chnnl;
            t_issue       = tick_no;
        end
        if (req0_cmplt === 1'b1) n_c0++;
        if (req1_cmplt === 1'b1) n_c1++;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_strt  = 1'b0;
        req1_strt  = 1'b0;
        adc_hang   = 1'b0;
        tick();
        check("rst_strt_cnv",   32'(strt_cnv),    32'd0);
        check("rst_chnnl",      32'(chnnl),       32'd0);
        check("rst_req0_cmplt", 32'(req0_cmplt),  32'd0);
        check("rst_req1_cmplt", 32'(req1_cmplt),  32'd0);
        check("rst_req0_res",   32'(req0_res),    32'h000);
        check("rst_req1_res",   32'(req1_res),    32'h000);
        check("rst_err",        32'(err_timeout), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic wait_cmplt(input int who, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if ((who == 0 && req0_cmplt === 1'b1) || (who == 1 && req1_cmplt === 1'b1)) ok = 1'b1;
        end
    endtask

    typedef struct {
        int          req;
        logic [2:0]  ch;
        logic [11:0] val;
        int          lat;
        logic [2:0]  exp_ch;
        logic [11:0] exp_res;
        logic [11:0] exp_other;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit ok;

        vecs[0] = '{0, 3'd1, 12'hA5C, 2, 3'd1, 12'hA5C, 12'h000};
        vecs[1] = '{1, 3'd7, 12'h3C1, 0, 3'd7, 12'h3C1, 12'hA5C};
        vecs[2] = '{0, 3'd0, 12'h000, 5, 3'd0, 12'h000, 12'h3C1};
        vecs[3] = '{1, 3'd4, 12'h800, 3, 3'd4, 12'h800, 12'h000};
        vecs[4] = '{0, 3'd6, 12'h7FF, 1, 3'd6, 12'h7FF, 12'h800};

        model_reset();
        env_reset();
        tick_no = 0;
        do_reset();

        // Single requests from the table
        for (int i = 0; i < 5; i++) begin
            adc_fixed   = 1'b1;
            adc_val     = vecs[i].val;
            adc_lat_cfg = vecs[i].lat;
            clear_log();
            if (vecs[i].req == 0) begin
                req0_strt = 1'b1; req0_chnnl = vecs[i].ch;
            end else begin
                req1_strt = 1'b1; req1_chnnl = vecs[i].ch;
            end
            tick();
            req0_strt = 1'b0;
            req1_strt = 1'b0;
            wait_cmplt(vecs[i].req, 40, ok);
            check($sformatf("vec%0d_done", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_res", i),
                  32'(vecs[i].req == 0 ? req0_res : req1_res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_other_res", i),
                  32'(vecs[i].req == 0 ? req1_res : req0_res), 32'(vecs[i].exp_other));
            check($sformatf("vec%0d_chnnl", i), 32'(last_issue_ch), 32'(vecs[i].exp_ch));
            repeat (3) tick();
            check($sformatf("vec%0d_strt_count", i), 32'(n_strt), 32'd1);
            check($sformatf("vec%0d_cmplt_count", i), 32'(n_c0 + n_c1), 32'd1);
        end

        // Simultaneous requests after reset: requester 0 first
        do_reset();
        adc_fixed   = 1'b0;
        adc_lat_cfg = 2;
        req0_strt = 1'b1; req0_chnnl = 3'd2;
        req1_strt = 1'b1; req1_chnnl = 3'd6;
        tick();
        req0_strt = 1'b0;
        req1_strt = 1'b0;
        wait_cmplt(1, 60, ok);
        check("simul_done", 32'(ok), 32'd1);
        repeat (6) tick();
        check("simul_strt_count", 32'(n_strt), 32'd2);
        check("simul_first_ch",  32'(grants.size() > 0 ? grants[0] : -1), 32'd2);
        check("simul_second_ch", 32'(grants.size() > 1 ? grants[1] : -1), 32'd6);

        // Fairness: both re-request on every completion
        do_reset();
        adc_lat_cfg = -1;
        req0_chnnl = 3'd3;
        req1_chnnl = 3'd4;
        req0_strt  = 1'b1;
        req1_strt  = 1'b1;
        for (int i = 0; i < 200 && grants.size() < 8; i++) begin
            tick();
            req0_strt = req0_cmplt;
            req1_strt = req1_cmplt;
        end
        req0_strt = 1'b0;
        req1_strt = 1'b0;
        check("fair_grant_count", 32'(grants.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < grants.size(); i++)
            check($sformatf("fair_grant%0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'd3 : 32'd4);
        repeat (40) tick();

        // Restart while in service is ignored
        do_reset();
        adc_lat_cfg = 8;
        req1_strt = 1'b1; req1_chnnl = 3'd6;
        tick();
        req1_strt = 1'b0;
        repeat (4) tick();
        req1_strt = 1'b1; req1_chnnl = 3'd5;
        tick();
        req1_strt = 1'b0;
        check("restart_chnnl_held", 32'(chnnl), 32'd6);
        wait_cmplt(1, 40, ok);
        check("restart_done", 32'(ok), 32'd1);
        repeat (10) tick();
        check("restart_strt_count", 32'(n_strt), 32'd1);
        check("restart_chnnl_end", 32'(chnnl), 32'd6);

        // Hung converter
        do_reset();
        adc_hang = 1'b1;
        req0_strt = 1'b1; req0_chnnl = 3'd1;
        tick();
        req0_strt = 1'b0;
`ifdef A2D_ARB_TIMEOUT_EN
        wait_cmplt(0, 40, ok);
        check("to_done", 32'(ok), 32'd1);
        check("to_latency", 32'(tick_no - (t_issue + 1)), 32'd16);
        check("to_res", 32'(req0_res), 32'hFFF);
        check("to_err", 32'(err_timeout), 32'd1);
        repeat (5) tick();
        check("to_err_sticky", 32'(err_timeout), 32'd1);
`else
        repeat (40) tick();
        check("hang_no_cmplt", 32'(n_c0), 32'd0);
        check("hang_no_err", 32'(err_timeout), 32'd0);
`endif
        do_reset();
        check("hang_err_cleared", 32'(err_timeout), 32'd0);

        // Asynchronous reset mid-WAIT with requester 1 pending
        adc_lat_cfg = 20;
        req0_strt = 1'b1; req0_chnnl = 3'd3;
        tick();
        req0_strt = 1'b0;
        repeat (4) tick();
        req1_strt = 1'b1; req1_chnnl = 3'd5;
        tick();
        req1_strt = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_strt_cnv",   32'(strt_cnv),    32'd0);
        check("arst_chnnl",      32'(chnnl),       32'd0);
        check("arst_req0_cmplt", 32'(req0_cmplt),  32'd0);
        check("arst_req1_cmplt", 32'(req1_cmplt),  32'd0);
        check("arst_req0_res",   32'(req0_res),    32'd0);
        check("arst_req1_res",   32'(req1_res),    32'd0);
        check("arst_err",        32'(err_timeout), 32'd0);
        model_reset();
        env_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        clear_log();
        repeat (15) tick();
        check("arst_no_strt", 32'(n_strt), 32'd0);

        // Randomized traffic against the model
        do_reset();
        adc_lat_cfg = -1;
        adc_fixed   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            req0_strt  = ($urandom_range(3, 0) == 0);
            req0_chnnl = 3'($urandom);
            req1_strt  = ($urandom_range(4, 0) == 0);
            req1_chnnl = 3'($urandom);
            tick();
        end
        req0_strt = 1'b0;
        req1_strt = 1'b0;
        repeat (40) tick();
        check("rand_activity", 32'(n_strt > 20), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
